// File: rtl/icache_pkg.sv
// Shared widths and FSM state encoding for the L1 instruction-cache tag compare stage.
package icache_pkg;
    localparam int OFFSET_SIZE = 5;
    localparam int INDEX_SIZE  = 8;
    localparam int TAG_SIZE    = 64 - (OFFSET_SIZE + INDEX_SIZE);
    localparam int VALID_BIT   = 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_REPLAY = 3'd4;
endpackage

// File: rtl/tag_comparator.sv
// Combinational tag match: a hit needs a valid line whose stored tag equals the fetch tag.
module tag_comparator
    import icache_pkg::*;
#(
    parameter int tagSize = TAG_SIZE
) (
    input  logic               valid_i,
    input  logic [tagSize-1:0] storedTag_i,
    input  logic [tagSize-1:0] fetchTag_i,
    output logic               hit_o
);
    assign hit_o = valid_i & (storedTag_i == fetchTag_i);
endmodule

// File: rtl/cache_tag_compare.sv
// Registers the tag lookup result and, on a miss, runs the refill handshake and tag write-back.
module cache_tag_compare
    import icache_pkg::*;
#(
    parameter int offsetSize = OFFSET_SIZE,
    parameter int indexSize  = INDEX_SIZE,
    parameter int tagSize    = 64 - (offsetSize + indexSize)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flushPipeline_i,
    input  logic                  enable_i,
    input  logic [tagSize-1:0]    tag_i,
    input  logic [tagSize:0]      queriedTag_i,
    input  logic [indexSize-1:0]  index_i,
    input  logic [offsetSize-1:0] offset_i,
    input  logic                  memGrant_i,
    input  logic                  memDone_i,
    output logic                  hit_o,
    output logic                  miss_o,
    output logic                  enable_o,
    output logic [tagSize-1:0]    tag_o,
    output logic [indexSize-1:0]  index_o,
    output logic [offsetSize-1:0] offset_o,
    output logic                  memReq_o,
    output logic [63:0]           memAddr_o,
    output logic [tagSize-1:0]    newTag_o,
    output logic [indexSize-1:0]  newIndex_o,
    output logic                  updateEnable_o,
    output logic                  tagQueryStall_o
);
    logic [2:0]            state_q, state_d;
    logic                  enable_q, enable_d, hit_q, hit_d, miss_q, miss_d;
    logic                  flushed_q, flushed_d;
    logic [tagSize-1:0]    tag_q, tag_d, missTag_q, missTag_d;
    logic [indexSize-1:0]  index_q, index_d, missIndex_q, missIndex_d;
    logic [offsetSize-1:0] offset_q, offset_d, missOffset_q, missOffset_d;
    logic                  cmpHit;

    tag_comparator #(.tagSize(tagSize)) u_cmp (
        .valid_i     (queriedTag_i[VALID_BIT]),
        .storedTag_i (queriedTag_i[tagSize:1]),
        .fetchTag_i  (tag_i),
        .hit_o       (cmpHit)
    );

    always_comb begin
        state_d      = state_q;
        enable_d     = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        flushed_d    = flushed_q;
        tag_d        = tag_q;
        index_d      = index_q;
        offset_d     = offset_q;
        missTag_d    = missTag_q;
        missIndex_d  = missIndex_q;
        missOffset_d = missOffset_q;
        case (state_q)
            S_IDLE: begin
                flushed_d = 1'b0;
                // miss_q marks the miss-report cycle: upstream is already stalled, so start the refill
                if (flushPipeline_i) begin
                    tag_d    = '0;
                    index_d  = '0;
                    offset_d = '0;
                end else if (miss_q) begin
                    state_d = S_REQ;
                end else if (enable_i) begin
                    enable_d = 1'b1;
                    hit_d    = cmpHit;
                    miss_d   = ~cmpHit;
                    tag_d    = tag_i;
                    index_d  = index_i;
                    offset_d = offset_i;
                    if (!cmpHit) begin
                        missTag_d    = tag_i;
                        missIndex_d  = index_i;
                        missOffset_d = offset_i;
                    end
                end
            end
            S_REQ: begin
                if (flushPipeline_i) flushed_d = 1'b1;
                if (memGrant_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flushPipeline_i) flushed_d = 1'b1;
                if (memDone_i) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                // a flush seen at any point of the refill drops the replay but never the tag write
                if (flushPipeline_i || flushed_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_REPLAY;
                    enable_d = 1'b1;
                    hit_d    = 1'b1;
                    tag_d    = missTag_q;
                    index_d  = missIndex_q;
                    offset_d = missOffset_q;
                end
            end
            S_REPLAY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            enable_q  <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            flushed_q <= 1'b0;
            tag_q     <= '0;
            index_q   <= '0;
            offset_q  <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            flushed_q <= flushed_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            offset_q  <= offset_d;
        end
    end

    always_ff @(posedge clock_i) begin
        missTag_q    <= missTag_d;
        missIndex_q  <= missIndex_d;
        missOffset_q <= missOffset_d;
    end

    assign enable_o        = enable_q;
    assign hit_o           = hit_q;
    assign miss_o          = miss_q;
    assign tag_o           = tag_q;
    assign index_o         = index_q;
    assign offset_o        = offset_q;
    assign memReq_o        = (state_q == S_REQ);
    assign memAddr_o       = memReq_o ? {missTag_q, missIndex_q, {offsetSize{1'b0}}} : 64'd0;
    assign updateEnable_o  = (state_q == S_UPDATE);
    assign newTag_o        = updateEnable_o ? missTag_q : '0;
    assign newIndex_o      = updateEnable_o ? missIndex_q : '0;
    assign tagQueryStall_o = (state_q != S_IDLE) | miss_q;
endmodule

// File: tb/tb_cache_tag_compare.sv
// Randomized bench: a transaction-level timeline model predicts every output cycle of the tag compare stage.
module tb_cache_tag_compare;
    localparam int OS   = 5;
    localparam int IS   = 8;
    localparam int TS   = 51;
    localparam int MAXC = 2048;

    logic          clock_i = 1'b0;
    logic          reset_i, flushPipeline_i, enable_i, memGrant_i, memDone_i;
    logic [TS-1:0] tag_i;
    logic [TS:0]   queriedTag_i;
    logic [IS-1:0] index_i;
    logic [OS-1:0] offset_i;
    logic          hit_o, miss_o, enable_o, memReq_o, updateEnable_o, tagQueryStall_o;
    logic [TS-1:0] tag_o, newTag_o;
    logic [IS-1:0] index_o, newIndex_o;
    logic [OS-1:0] offset_o;
    logic [63:0]   memAddr_o;

    cache_tag_compare dut (
        .clock_i(clock_i), .reset_i(reset_i), .flushPipeline_i(flushPipeline_i),
        .enable_i(enable_i), .tag_i(tag_i), .queriedTag_i(queriedTag_i),
        .index_i(index_i), .offset_i(offset_i), .memGrant_i(memGrant_i),
        .memDone_i(memDone_i), .hit_o(hit_o), .miss_o(miss_o), .enable_o(enable_o),
        .tag_o(tag_o), .index_o(index_o), .offset_o(offset_o), .memReq_o(memReq_o),
        .memAddr_o(memAddr_o), .newTag_o(newTag_o), .newIndex_o(newIndex_o),
        .updateEnable_o(updateEnable_o), .tagQueryStall_o(tagQueryStall_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic en, flush, grant, done;
        logic [TS-1:0] tag;
        logic [TS:0]   qtag;
        logic [IS-1:0] idx;
        logic [OS-1:0] off;
    } in_t;

    typedef struct packed {
        logic en, hit, miss, req, upd, stall, zf;
        logic [TS-1:0] tag;
        logic [IS-1:0] idx;
        logic [OS-1:0] off;
        logic [TS-1:0] ntag;
        logic [IS-1:0] nidx;
    } exp_t;

    in_t  stim [MAXC];
    exp_t ex   [MAXC];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".enable"}, enable_o, 0);
        chk({nm, ".hit"}, hit_o, 0);
        chk({nm, ".miss"}, miss_o, 0);
        chk({nm, ".tag"}, tag_o, 0);
        chk({nm, ".index"}, index_o, 0);
        chk({nm, ".offset"}, offset_o, 0);
        chk({nm, ".memReq"}, memReq_o, 0);
        chk({nm, ".memAddr"}, memAddr_o, 0);
        chk({nm, ".newTag"}, newTag_o, 0);
        chk({nm, ".newIndex"}, newIndex_o, 0);
        chk({nm, ".update"}, updateEnable_o, 0);
        chk({nm, ".stall"}, tagQueryStall_o, 0);
    endtask

    // Plan one lookup at cycle t. g = extra REQ cycles before grant, d = extra WAIT cycles
    // before done; fl: 0 none, 1 flush in REQ, 2 in WAIT, 3 in UPDATE, 4 flush with the lookup.
    task automatic plan(input int t, input logic [TS-1:0] ftag, input logic [TS:0] q,
                        input logic [IS-1:0] ix, input logic [OS-1:0] of,
                        input int g, input int d, input int fl, output int nxt);
        bit h;
        int u;
        h = q[0] && (q[TS:1] == ftag);
        stim[t].en = 1'b1; stim[t].tag = ftag; stim[t].qtag = q;
        stim[t].idx = ix; stim[t].off = of;
        if (fl == 4) begin
            stim[t].flush = 1'b1;
            ex[t+1].zf = 1'b1;
            nxt = t + 1;
            return;
        end
        ex[t+1].en = 1'b1; ex[t+1].hit = h; ex[t+1].miss = !h;
        ex[t+1].tag = ftag; ex[t+1].idx = ix; ex[t+1].off = of;
        if (h) begin
            nxt = t + 1;
            return;
        end
        ex[t+1].stall = 1'b1;
        for (int c = t + 2; c <= t + 2 + g; c++) begin
            ex[c].req = 1'b1; ex[c].stall = 1'b1; ex[c].tag = ftag; ex[c].idx = ix;
        end
        stim[t+2+g].grant = 1'b1;
        for (int c = t + 3 + g; c <= t + 3 + g + d; c++) ex[c].stall = 1'b1;
        stim[t+3+g+d].done = 1'b1;
        u = t + 4 + g + d;
        ex[u].upd = 1'b1; ex[u].stall = 1'b1; ex[u].ntag = ftag; ex[u].nidx = ix;
        if (fl == 1) stim[t + 2 + $urandom_range(0, g)].flush = 1'b1;
        if (fl == 2) stim[t + 3 + g + $urandom_range(0, d)].flush = 1'b1;
        if (fl == 3) stim[u].flush = 1'b1;
        if (fl == 0) begin
            ex[u+1].en = 1'b1; ex[u+1].hit = 1'b1; ex[u+1].stall = 1'b1;
            ex[u+1].tag = ftag; ex[u+1].idx = ix; ex[u+1].off = of;
            nxt = u + 2;
        end else begin
            nxt = u + 1;
        end
    endtask

    task automatic apply(input int c);
        enable_i = stim[c].en; flushPipeline_i = stim[c].flush;
        memGrant_i = stim[c].grant; memDone_i = stim[c].done;
        tag_i = stim[c].tag; queriedTag_i = stim[c].qtag;
        index_i = stim[c].idx; offset_i = stim[c].off;
    endtask

    task automatic compare(input int c);
        exp_t e;
        e = ex[c];
        chk("enable", enable_o, e.en);
        chk("hit", hit_o, e.hit);
        chk("miss", miss_o, e.miss);
        chk("memReq", memReq_o, e.req);
        chk("update", updateEnable_o, e.upd);
        chk("stall", tagQueryStall_o, e.stall);
        chk("newTag", newTag_o, e.ntag);
        chk("newIndex", newIndex_o, e.nidx);
        if (e.req) chk("memAddr", memAddr_o, {e.tag, e.idx, 5'b0});
        if (e.en || e.zf) begin
            chk("tag", tag_o, e.tag);
            chk("index", index_o, e.idx);
            chk("offset", offset_o, e.off);
        end
    endtask

    initial begin
        int t, ncyc, kind, fl;
        logic [TS-1:0] ft, one;
        logic [TS:0]   q;
        logic          wait_cyc;

        for (int i = 0; i < MAXC; i++) begin
            stim[i] = '0;
            ex[i]   = '0;
        end

        // directed scenarios followed by random lookups
        t = 0;
        plan(t, 51'h12345, {51'h12345, 1'b1}, 8'h3C, 5'h04, 0, 0, 0, t);
        plan(t, 51'h12345, {51'h12345, 1'b0}, 8'h3C, 5'h08, 2, 3, 0, t);
        plan(t, 51'h2BEEF, {51'h2BEE0, 1'b1}, 8'h51, 5'h1F, 0, 2, 2, t);
        plan(t, 51'h00777, {51'h00777, 1'b1}, 8'h90, 5'h03, 0, 0, 4, t);
        for (int i = 0; i < 8; i++) begin
            ft = 51'h4000 + 51'(i);
            plan(t, ft, {ft, 1'b1}, 8'(8'hA0 + i), 5'(i), 0, 0, 0, t);
        end
        while (t < MAXC - 60) begin
            ft   = {$urandom, $urandom};
            one  = 51'd1 << $urandom_range(0, TS - 1);
            kind = $urandom_range(0, 3);
            case (kind)
                0:       q = {ft, 1'b1};
                1:       q = {ft ^ one, 1'b1};
                2:       q = {ft, 1'b0};
                default: q = {51'({$urandom, $urandom}), 1'($urandom)};
            endcase
            fl = $urandom_range(0, 9);
            if (fl > 4) fl = 0;
            plan(t, ft, q, 8'($urandom), 5'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), fl, t);
            t = t + $urandom_range(0, 2);
        end
        ncyc = t + 3;

        // inputs that must have no effect: lookups while busy, handshakes in the wrong state
        for (int c = 0; c < ncyc; c++) begin
            wait_cyc = ex[c].stall && !ex[c].req && !ex[c].upd && !ex[c].en;
            if (ex[c].stall && !stim[c].en) begin
                stim[c].en   = 1'($urandom);
                stim[c].tag  = {$urandom, $urandom};
                stim[c].qtag = {$urandom, $urandom};
                stim[c].idx  = 8'($urandom);
            end
            if (!ex[c].req) stim[c].grant = stim[c].grant | 1'($urandom);
            if (!wait_cyc)  stim[c].done  = stim[c].done | 1'($urandom);
        end

        reset_i = 1'b0;
        apply(MAXC - 1);
        enable_i = 1'b1;
        memGrant_i = 1'b1;
        memDone_i = 1'b1;
        repeat (2) tick();
        check_zero("reset");

        reset_i = 1'b1;
        apply(0);
        for (int c = 0; c < ncyc; c++) begin
            tick();
            cyc = c + 1;
            compare(c + 1);
            apply(c + 1);
        end

        // reset while the refill request is outstanding
        enable_i = 1'b1; flushPipeline_i = 1'b0; memGrant_i = 1'b0; memDone_i = 1'b0;
        tag_i = 51'hABC; queriedTag_i = {51'hABC, 1'b0}; index_i = 8'h11; offset_i = 5'h2;
        tick();
        chk("rstReq.miss", miss_o, 1);
        enable_i = 1'b0;
        tick();
        chk("rstReq.memReq", memReq_o, 1);
        chk("rstReq.memAddr", memAddr_o, {51'hABC, 8'h11, 5'b0});
        reset_i = 1'b0;
        tick();
        check_zero("rstReq");
        reset_i = 1'b1;
        enable_i = 1'b1; tag_i = 51'h777; queriedTag_i = {51'h777, 1'b1}; index_i = 8'h22;
        tick();
        chk("postRst.enable", enable_o, 1);
        chk("postRst.hit", hit_o, 1);
        chk("postRst.index", index_o, 8'h22);
        chk("postRst.stall", tagQueryStall_o, 0);
        enable_i = 1'b0; memGrant_i = 1'b1; memDone_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postRst.update", updateEnable_o, 0);
            chk("postRst.memReq", memReq_o, 0);
            chk("postRst.stall", tagQueryStall_o, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
